jpeg_slide_ctrl: RTL and testbench
==================================

JPEG_SLIDE_CTRL -- requirements
Module: jpeg_slide_ctrl

Interface
REQ-001 SHALL have parameter NUM_OF_JPG, default 32, number of images stored in flash.
REQ-002 SHALL have parameter SPI_FLASH_ADDR_WIDTH, default 24, width of the flash byte address.
REQ-003 SHALL have parameter START_ADDR, default 24'h100000, flash address of image 0.
REQ-004 SHALL have parameter ADDR_OFFSET, default 24'h010000, address stride between images.
REQ-005 SHALL have parameter DEBOUNCE_CYC, default 65536, cycles a button must be stable high to register.
REQ-006 SHALL have parameter AUTO_CYCLES, default 2^26, idle cycles before auto-advance (used only with the macro).
REQ-007 SHALL have i_sysclk  input  1  system clock; all logic on its rising edge.
REQ-008 SHALL have i_rst  input  1  synchronous active-high reset.
REQ-009 SHALL have i_next  input  1  raw next button, active-high, already synchronised to i_sysclk.
REQ-010 SHALL have i_back  input  1  raw back button, active-high, already synchronised to i_sysclk.
REQ-011 SHALL have i_interrupt  input  1  abort the current load and reload the same image.
REQ-012 SHALL have o_dec_rst  output  1  one-cycle reset pulse to the decoder and line buffer.
REQ-013 SHALL have o_rd_req  output  1  flash streamer start request.
REQ-014 SHALL have i_rd_ack  input  1  flash streamer accepts the request.
REQ-015 SHALL have o_rd_addr  output  SPI_FLASH_ADDR_WIDTH  start address of the image.
REQ-016 SHALL have i_dec_done  input  1  one-cycle pulse when the decoder has output the last pixel.
REQ-017 SHALL have o_img_idx  output  log2(NUM_OF_JPG)  current image index.
REQ-018 SHALL have o_busy  output  1  high in every state except S_IDLE.

Function
REQ-019 SHALL implement the states S_RST_DEC, S_REQ, S_WAIT and S_IDLE.
REQ-020 S_RST_DEC SHALL assert o_dec_rst for exactly one cycle, load o_rd_addr = (START_ADDR + o_img_idx*ADDR_OFFSET) truncated to SPI_FLASH_ADDR_WIDTH, then go to S_REQ.
REQ-021 S_REQ SHALL hold o_rd_req high with o_rd_addr stable until i_rd_ack is sampled high, deassert o_rd_req the next cycle, and go to S_WAIT.
REQ-022 S_WAIT SHALL go to S_IDLE on i_dec_done, or to S_RST_DEC on i_dec_done when a pending command exists.
REQ-023 Debounce SHALL use a per-button counter; a button registers as pressed only after DEBOUNCE_CYC consecutive high cycles, and any low sample clears the counter.
REQ-024 A next or back event SHALL be a one-cycle pulse on the rising edge of the debounced level.
REQ-025 An event in S_IDLE SHALL update o_img_idx the same cycle and go to S_RST_DEC.
  - next: idx+1, wrapping NUM_OF_JPG-1 to 0.
  - back: idx-1, wrapping 0 to NUM_OF_JPG-1.
REQ-026 Next and back events in the same cycle SHALL cancel and cause no action.
REQ-027 Events outside S_IDLE SHALL be stored in a one-deep pending register; the latest event overwrites older ones, and the pending command executes on i_dec_done.
REQ-028 i_interrupt in S_REQ or S_WAIT SHALL drop o_rd_req, clear the pending command, keep o_img_idx, and go to S_RST_DEC the next cycle.
REQ-029 i_interrupt in S_IDLE or S_RST_DEC SHALL be ignored.
REQ-030 i_rd_ack outside S_REQ and i_dec_done outside S_WAIT SHALL be ignored.

Reset
REQ-031 On i_rst the block SHALL set o_img_idx=0, o_rd_req=0, o_rd_addr=START_ADDR, o_dec_rst=0, clear the pending command, debounce counters and auto timer, and set the state to S_RST_DEC.
REQ-032 After reset release the block SHALL load image 0 automatically with no button press.
REQ-033 i_rst asserted mid-load SHALL abort immediately, with o_rd_req low in the cycle after i_rst is sampled.

Configuration
REQ-034 With macro JPEG_SLIDE_AUTO_EN defined, a counter SHALL run only in S_IDLE; after AUTO_CYCLES idle cycles it generates a next event, and it is cleared on leaving S_IDLE or on any button event.
REQ-035 Without JPEG_SLIDE_AUTO_EN, the counter SHALL not exist and S_IDLE SHALL be left only on a next or back event.

Verification
(Bench parameters: START_ADDR=0x100000, ADDR_OFFSET=0x10000, NUM_OF_JPG=32, DEBOUNCE_CYC=4.)
REQ-036 Release i_rst -> o_dec_rst pulses once, then o_rd_req=1 with o_rd_addr=0x100000; an ack after 5 cycles gives o_rd_req=0 the next cycle.
REQ-037 In S_IDLE at idx 0, press back for 4 cycles -> o_img_idx=31 and o_rd_addr=0x2F0000; at idx 31, press next -> idx 0 and addr 0x100000.
REQ-038 A 3-cycle i_next glitch -> no event and the state stays S_IDLE.
REQ-039 During S_WAIT at idx 5, press next, next, then back; then pulse i_dec_done -> one reload only, at idx 4 with addr 0x140000.
REQ-040 i_interrupt in S_WAIT at idx 7 -> o_dec_rst pulse, then a re-request at 0x170000 with o_img_idx unchanged.
REQ-041 With JPEG_SLIDE_AUTO_EN defined and AUTO_CYCLES=100 -> reload of idx+1 after 100 idle cycles; a press at cycle 50 restarts the count.

Source files
------------

// File: rtl/jpeg_slide_ctrl_if.sv
// Read-request handshake between the slideshow controller and the SPI flash streamer.
interface jpeg_slide_ctrl_if #(
    parameter int unsigned ADDR_W = 24
) ();
    logic              rd_req;
    logic              rd_ack;
    logic [ADDR_W-1:0] rd_addr;

    modport master (output rd_req, output rd_addr, input rd_ack);
    modport slave  (input rd_req, input rd_addr, output rd_ack);
endinterface

// File: rtl/jpeg_slide_ctrl.sv
// Button-driven JPEG slideshow sequencer: resets the decoder and requests each image from flash.
// Define JPEG_SLIDE_AUTO_EN to add an idle timer that auto-advances to the next image.
module jpeg_slide_ctrl #(
    parameter int unsigned                     NUM_OF_JPG           = 32,
    parameter int unsigned                     SPI_FLASH_ADDR_WIDTH = 24,
    parameter logic [SPI_FLASH_ADDR_WIDTH-1:0] START_ADDR           = 24'h100000,
    parameter logic [SPI_FLASH_ADDR_WIDTH-1:0] ADDR_OFFSET          = 24'h010000,
    parameter int unsigned                     DEBOUNCE_CYC         = 65536,
    parameter int unsigned                     AUTO_CYCLES          = 2 ** 26,
    localparam int unsigned                    IDX_W = (NUM_OF_JPG > 1) ? $clog2(NUM_OF_JPG) : 1
) (
    input  logic                      i_sysclk,
    input  logic                      i_rst,
    input  logic                      i_next,
    input  logic                      i_back,
    input  logic                      i_interrupt,
    output logic                      o_dec_rst,
    jpeg_slide_ctrl_if.master         rd_if,
    input  logic                      i_dec_done,
    output logic [IDX_W-1:0]          o_img_idx,
    output logic                      o_busy
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {S_RST_DEC, S_REQ, S_WAIT, S_IDLE} state_e;
    typedef enum logic [1:0] {P_NONE, P_NEXT, P_BACK} pend_e;

    state_e                          r_state, w_state_nxt;
    pend_e                           r_pend, w_pend_nxt, w_cmd, w_sel;
    logic [IDX_W-1:0]                r_idx, w_idx_nxt;
    logic [SPI_FLASH_ADDR_WIDTH-1:0] r_addr, w_addr_nxt, w_img_addr;
    logic [DB_W-1:0]                 r_next_cnt, r_back_cnt;
    logic                            r_next_prev, r_back_prev;
    logic                            w_next_lvl, w_back_lvl, w_next_ev, w_back_ev, w_auto_ev;

    function automatic logic [IDX_W-1:0] f_step(input pend_e cmd, input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] last;
        last = IDX_W'(NUM_OF_JPG - 1);
        if (cmd == P_NEXT) return (idx == last) ? '0 : idx + IDX_W'(1);
        if (cmd == P_BACK) return (idx == '0) ? last : idx - IDX_W'(1);
        return idx;
    endfunction

    assign w_next_lvl = (r_next_cnt == DB_W'(DEBOUNCE_CYC));
    assign w_back_lvl = (r_back_cnt == DB_W'(DEBOUNCE_CYC));
    assign w_next_ev  = w_next_lvl & ~r_next_prev;
    assign w_back_ev  = w_back_lvl & ~r_back_prev;

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_next_cnt  <= '0;
            r_back_cnt  <= '0;
            r_next_prev <= 1'b0;
            r_back_prev <= 1'b0;
        end else begin
            // Counters saturate at the threshold so a held button yields a single event.
            r_next_cnt  <= !i_next ? '0 : (w_next_lvl ? r_next_cnt : r_next_cnt + DB_W'(1));
            r_back_cnt  <= !i_back ? '0 : (w_back_lvl ? r_back_cnt : r_back_cnt + DB_W'(1));
            r_next_prev <= w_next_lvl;
            r_back_prev <= w_back_lvl;
        end
    end

`ifdef JPEG_SLIDE_AUTO_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_CYCLES + 1);
    logic [AUTO_W-1:0] r_auto_cnt;

    assign w_auto_ev = (r_state == S_IDLE) && (r_auto_cnt == AUTO_W'(AUTO_CYCLES - 1));

    always_ff @(posedge i_sysclk) begin
        if (i_rst || r_state != S_IDLE || w_next_ev || w_back_ev || w_auto_ev) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
        end
    end
`else
    assign w_auto_ev = 1'b0;
`endif

    // Simultaneous next and back cancel each other.
    always_comb begin
        w_cmd = P_NONE;
        if ((w_next_ev | w_auto_ev) && !w_back_ev) w_cmd = P_NEXT;
        if (w_back_ev && !(w_next_ev | w_auto_ev)) w_cmd = P_BACK;
    end

    assign w_img_addr = START_ADDR + SPI_FLASH_ADDR_WIDTH'(r_idx) * ADDR_OFFSET;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        w_sel       = (w_cmd != P_NONE) ? w_cmd : r_pend;
        unique case (r_state)
            S_RST_DEC: begin
                w_addr_nxt  = w_img_addr;
                w_state_nxt = S_REQ;
                if (w_cmd != P_NONE) w_pend_nxt = w_cmd;
            end
            S_REQ: begin
                if (i_interrupt) begin
                    w_pend_nxt  = P_NONE;
                    w_state_nxt = S_RST_DEC;
                end else begin
                    if (w_cmd != P_NONE) w_pend_nxt = w_cmd;
                    if (rd_if.rd_ack) w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_interrupt) begin
                    w_pend_nxt  = P_NONE;
                    w_state_nxt = S_RST_DEC;
                end else if (i_dec_done) begin
                    w_pend_nxt = P_NONE;
                    if (w_sel != P_NONE) begin
                        w_idx_nxt   = f_step(w_sel, r_idx);
                        w_state_nxt = S_RST_DEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_cmd != P_NONE) begin
                    w_pend_nxt = w_cmd;
                end
            end
            S_IDLE: begin
                if (w_cmd != P_NONE) begin
                    w_idx_nxt   = f_step(w_cmd, r_idx);
                    w_state_nxt = S_RST_DEC;
                end
            end
            default: w_state_nxt = S_RST_DEC;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_state <= S_RST_DEC;
            r_pend  <= P_NONE;
            r_idx   <= '0;
            r_addr  <= START_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_idx   <= w_idx_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Gated by i_rst so the pulse appears only once the decoder reset is actually released.
    assign o_dec_rst     = (r_state == S_RST_DEC) && !i_rst;
    assign rd_if.rd_req  = (r_state == S_REQ);
    assign rd_if.rd_addr = r_addr;
    assign o_img_idx     = r_idx;
    assign o_busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_jpeg_slide_ctrl.sv
// Directed self-checking bench for jpeg_slide_ctrl (DEBOUNCE_CYC=4, AUTO_CYCLES=100).
module tb_jpeg_slide_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nxt = 1'b0;
    logic       bck = 1'b0;
    logic       intr = 1'b0;
    logic       done = 1'b0;
    logic       dec_rst;
    logic [4:0] idx;
    logic       busy;
    int         total = 0;
    int         bad = 0;

    jpeg_slide_ctrl_if #(.ADDR_W(24)) rd_if ();

    jpeg_slide_ctrl #(
        .NUM_OF_JPG          (32),
        .SPI_FLASH_ADDR_WIDTH(24),
        .START_ADDR          (24'h100000),
        .ADDR_OFFSET         (24'h010000),
        .DEBOUNCE_CYC        (4),
        .AUTO_CYCLES         (100)
    ) dut (
        .i_sysclk   (clk),
        .i_rst      (rst),
        .i_next     (nxt),
        .i_back     (bck),
        .i_interrupt(intr),
        .o_dec_rst  (dec_rst),
        .rd_if      (rd_if.master),
        .i_dec_done (done),
        .o_img_idx  (idx),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic n, input logic b, input int cyc);
        nxt = n;
        bck = b;
        repeat (cyc) tick();
        nxt = 1'b0;
        bck = 1'b0;
    endtask

    // From S_REQ: ack, then decoder done -> S_IDLE.
    task automatic finish();
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic go_next();
        press(1'b1, 1'b0, 4);
        tick();
        tick();
        finish();
    endtask

    initial begin
        rd_if.rd_ack = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_req", {31'd0, rd_if.rd_req}, 32'd0);
        chk("rst_decrst", {31'd0, dec_rst}, 32'd0);
        chk("rst_idx", {27'd0, idx}, 32'd0);
        chk("rst_addr", {8'd0, rd_if.rd_addr}, 32'h100000);

        rst = 1'b0;
        #1;
        chk("boot_decrst", {31'd0, dec_rst}, 32'd1);
        tick();
        chk("boot_decrst_off", {31'd0, dec_rst}, 32'd0);
        chk("boot_req", {31'd0, rd_if.rd_req}, 32'd1);
        chk("boot_addr", {8'd0, rd_if.rd_addr}, 32'h100000);
        repeat (4) tick();
        chk("boot_req_hold", {31'd0, rd_if.rd_req}, 32'd1);
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        chk("boot_req_drop", {31'd0, rd_if.rd_req}, 32'd0);
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        chk("wait_ack_ignored", {31'd0, rd_if.rd_req}, 32'd0);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("boot_idle", {31'd0, busy}, 32'd0);

        press(1'b0, 1'b1, 4);
        tick();
        chk("back_wrap_idx", {27'd0, idx}, 32'd31);
        tick();
        chk("back_wrap_addr", {8'd0, rd_if.rd_addr}, 32'h2F0000);
        chk("back_wrap_req", {31'd0, rd_if.rd_req}, 32'd1);
        finish();
        press(1'b1, 1'b0, 4);
        tick();
        chk("next_wrap_idx", {27'd0, idx}, 32'd0);
        tick();
        chk("next_wrap_addr", {8'd0, rd_if.rd_addr}, 32'h100000);
        finish();

        press(1'b1, 1'b0, 3);
        repeat (3) tick();
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_idx", {27'd0, idx}, 32'd0);
        press(1'b1, 1'b1, 4);
        repeat (2) tick();
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_idx", {27'd0, idx}, 32'd0);
        intr = 1'b1;
        done = 1'b1;
        tick();
        intr = 1'b0;
        done = 1'b0;
        chk("idle_intr_ignored", {31'd0, busy}, 32'd0);

        repeat (4) go_next();
        press(1'b1, 1'b0, 4);
        tick();
        tick();
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        chk("pend_start_idx", {27'd0, idx}, 32'd5);
        press(1'b1, 1'b0, 4);
        tick();
        press(1'b1, 1'b0, 4);
        tick();
        press(1'b0, 1'b1, 4);
        tick();
        chk("pend_held_idx", {27'd0, idx}, 32'd5);
        chk("pend_held_busy", {31'd0, busy}, 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("pend_idx", {27'd0, idx}, 32'd4);
        chk("pend_decrst", {31'd0, dec_rst}, 32'd1);
        tick();
        chk("pend_addr", {8'd0, rd_if.rd_addr}, 32'h140000);
        finish();
        repeat (5) tick();
        chk("pend_single", {31'd0, busy}, 32'd0);

        go_next();
        go_next();
        press(1'b1, 1'b0, 4);
        tick();
        tick();
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        press(1'b1, 1'b0, 4);
        tick();
        intr = 1'b1;
        tick();
        intr = 1'b0;
        chk("intr_req", {31'd0, rd_if.rd_req}, 32'd0);
        chk("intr_decrst", {31'd0, dec_rst}, 32'd1);
        chk("intr_idx", {27'd0, idx}, 32'd7);
        tick();
        chk("intr_rereq", {31'd0, rd_if.rd_req}, 32'd1);
        chk("intr_addr", {8'd0, rd_if.rd_addr}, 32'h170000);
        finish();
        chk("intr_pend_cleared", {31'd0, busy}, 32'd0);
        chk("intr_final_idx", {27'd0, idx}, 32'd7);

        press(1'b1, 1'b0, 4);
        tick();
        tick();
        chk("midrst_req", {31'd0, rd_if.rd_req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_req_drop", {31'd0, rd_if.rd_req}, 32'd0);
        chk("midrst_idx", {27'd0, idx}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_decrst", {31'd0, dec_rst}, 32'd1);
        tick();
        chk("midrst_addr", {8'd0, rd_if.rd_addr}, 32'h100000);
        finish();
        chk("midrst_idle", {31'd0, busy}, 32'd0);

`ifdef JPEG_SLIDE_AUTO_EN
        repeat (99) tick();
        chk("auto_early", {31'd0, busy}, 32'd0);
        tick();
        chk("auto_fire", {31'd0, busy}, 32'd1);
        chk("auto_idx", {27'd0, idx}, 32'd1);
        tick();
        finish();
        repeat (46) tick();
        press(1'b1, 1'b0, 4);
        tick();
        chk("auto_press_idx", {27'd0, idx}, 32'd2);
        tick();
        finish();
        repeat (99) tick();
        chk("auto_restart_early", {31'd0, busy}, 32'd0);
        tick();
        chk("auto_restart_fire", {27'd0, idx}, 32'd3);
`else
        repeat (150) tick();
        chk("no_auto_idle", {31'd0, busy}, 32'd0);
        chk("no_auto_idx", {27'd0, idx}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
